shift_serdes: RTL
=================

// Module: shift_serdes
// PURPOSE
//  Parametrised bidirectional serialiser/deserialiser built on the shift-register primitives.
//  TX channel: valid/ready parallel load, serial out. RX channel: serial in, parallel word out.
//  Bit rate is set by an external bit_en strobe; either bit order is selectable per frame.
//  Sits between word-level datapath logic and any 1-bit link (loopback, pin, test port).
// PARAMETERS
//  WIDTH  32               bits per frame (>=2)
//  CNT_W  $clog2(WIDTH)    bit-counter width (derived; do not override)
// PORTS
//  clk        in   1      sole clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  bit_en     in   1      shift strobe; one serial bit per cycle in which it is high
//  msb_first  in   1      bit order; latched at TX load / RX start, 0 = LSB first
//  tx_data    in   WIDTH  word to transmit
//  tx_valid   in   1      tx_data offered
//  tx_ready   out  1      TX idle, can accept a word
//  tx_bit     out  1      serial output; 1 when idle
//  tx_active  out  1      TX frame in progress
//  rx_bit     in   1      serial input
//  rx_start   in   1      begin RX frame (honoured only when RX idle)
//  rx_data    out  WIDTH  last completed word; held until the next completion
//  rx_valid   out  1      one-cycle pulse: rx_data updated
//  rx_err     out  1      parity error, qualified by rx_valid; tied 0 without SERDES_PARITY_EN
// BEHAVIOUR
//  Reset (rst high at posedge): both FSMs IDLE, counters 0, tx_bit=1, tx_ready=1, tx_active=0,
//   rx_data=0, rx_valid=0, rx_err=0. Aborts any frame in flight, with no rx_valid.
//  TX FSM IDLE->SHIFT[->PAR]->IDLE:
//   IDLE: tx_ready=1. tx_valid&tx_ready latches tx_data and msb_first, cnt=0, ->SHIFT.
//   bit_en in the load cycle is ignored.
//   SHIFT: tx_ready=0, tx_active=1, tx_bit = current LSB (or MSB), registered.
//   Each bit_en shifts once and increments cnt. bit_en at cnt==WIDTH-1 -> PAR (if enabled), else IDLE.
//   Each bit is held from the previous bit_en edge through the edge of the bit_en that retires it.
//   tx_ready is high the cycle after the last bit retires, so back-to-back frames have 1 idle cycle minimum.
//   tx_valid deassertion after handshake has no effect.
//  RX FSM IDLE->SHIFT[->PAR]->IDLE:
//   IDLE: rx_start latches msb_first, clears cnt, ->SHIFT. bit_en in the same cycle is not sampled.
//   SHIFT: each bit_en samples rx_bit. LSB-first: shift right, insert at [WIDTH-1]. MSB-first: shift left, insert at [0].
//   WIDTH-th sample: without parity, rx_data<=shifted word and rx_valid=1 on the next cycle, ->IDLE.
//   rx_start is ignored while not IDLE. rx_start in the cycle rx_valid is high starts a new frame.
//  Counters wrap never: the terminal count forces the transition; cnt is cleared on every frame start.
//  tx_bit, rx_data, rx_valid and rx_err are registered outputs. tx_ready and tx_active decode the registered FSM state.
// CONFIGURATION
//  SERDES_PARITY_EN defined: one even-parity bit (XOR of the word) follows the data on both channels.
//   TX PAR state drives parity for one bit_en. RX PAR state samples one extra bit.
//   rx_err = sampled ^ computed, presented with rx_valid. Frame length = WIDTH+1 bit_en.
//  Undefined: no PAR states, frame length = WIDTH bit_en, rx_err tied 0.
// STRUCTURE
//  Package shift_serdes_pkg: typedef enum logic[1:0] {IDLE,SHIFT,PAR} serdes_state_t; const IDLE_BIT=1'b1.
//  Sub-module bit_shift_core #(WIDTH): loadable left/right shift register plus CNT_W counter with terminal flag.
//   Instantiated once for TX and once for RX. The FSMs live in shift_serdes.
// TESTING (WIDTH=8)
//  rst high 2 cycles mid-idle -> tx_ready=1, tx_bit=1, tx_active=0, rx_valid=0, rx_data=8'h00.
//  TX 8'hC1, msb_first=0, bit_en every cycle -> tx_bit 1,0,0,0,0,0,1,1; tx_ready=1 after 8th bit_en.
//  RX msb_first=1, rx_bit 1,1,0,0,0,0,0,1 with bit_en every 3rd cycle -> rx_data=8'hC1, rx_valid high exactly 1 cycle.
//  Loopback tx_bit->rx_bit, rx_start on each TX handshake, words 8'h00 then 8'hFF back-to-back -> two rx_valid with same data.
//  rst asserted after 4 bits of a frame -> no rx_valid ever; next cycle tx_ready=1, tx_bit=1; new frame 8'h5A is correct.
//  SERDES_PARITY_EN: TX 8'hC1 -> 9th bit 1. RX 8'hC1 with parity bit 0 -> rx_valid=1, rx_err=1.

Source files
------------

// File: rtl/shift_serdes_pkg.sv
// rtl/shift_serdes_pkg.sv - FSM state type and line constants shared by the shift_serdes files
package shift_serdes_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} serdes_state_t;

  localparam logic IDLE_BIT = 1'b1;

endpackage

// File: rtl/bit_shift_core.sv
// rtl/bit_shift_core.sv - loadable left/right shift register with frame bit counter and terminal flag
module bit_shift_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_msb,
  input  logic             shift,
  input  logic             in_bit,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] next_data,
  output logic             head_next,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic             msb;
  logic [CNT_W-1:0] cnt;

  // MSB-first moves toward [WIDTH-1] and fills at [0]; LSB-first is the mirror image
  assign next_data = msb ? {data[WIDTH-2:0], in_bit} : {in_bit, data[WIDTH-1:1]};
  assign head_next = msb ? next_data[WIDTH-1] : next_data[0];
  assign last      = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      msb  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      msb  <= load_msb;
      cnt  <= '0;
    end else if (shift) begin
      data <= next_data;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_serdes.sv
// rtl/shift_serdes.sv - word-to-serial TX and serial-to-word RX channels paced by bit_en
// Optional even-parity bit after each frame when SERDES_PARITY_EN is defined.
module shift_serdes
  import shift_serdes_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_bit,
  output logic             tx_active,
  input  logic             rx_bit,
  input  logic             rx_start,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err
);

`ifdef SERDES_PARITY_EN
  localparam serdes_state_t AFTER_DATA = PAR;
`else
  localparam serdes_state_t AFTER_DATA = IDLE;
`endif

  serdes_state_t    tx_state, tx_next, rx_state, rx_next;
  logic             tx_load, tx_shift, tx_last, tx_head_next, tx_tail;
  logic             rx_load, rx_shift, rx_last, rx_head_next;
  logic [WIDTH-1:0] tx_word, tx_word_next, rx_word, rx_word_next;
  logic             unused_taps;

  assign unused_taps = ^{tx_word, tx_word_next, rx_head_next, rx_word, rx_word_next};

  bit_shift_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_tx_core (
    .clk(clk), .rst(rst), .load(tx_load), .load_data(tx_data), .load_msb(msb_first),
    .shift(tx_shift), .in_bit(1'b0), .data(tx_word), .next_data(tx_word_next),
    .head_next(tx_head_next), .last(tx_last)
  );

  bit_shift_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_rx_core (
    .clk(clk), .rst(rst), .load(rx_load), .load_data('0), .load_msb(msb_first),
    .shift(rx_shift), .in_bit(rx_bit), .data(rx_word), .next_data(rx_word_next),
    .head_next(rx_head_next), .last(rx_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      rx_state <= IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    tx_next  = tx_state;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    case (tx_state)
      IDLE: if (tx_valid) begin
        tx_load = 1'b1;
        tx_next = SHIFT;
      end
      SHIFT: if (bit_en) begin
        tx_shift = 1'b1;
        if (tx_last) tx_next = AFTER_DATA;
      end
      PAR: if (bit_en) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  always_comb begin
    rx_next  = rx_state;
    rx_load  = 1'b0;
    rx_shift = 1'b0;
    case (rx_state)
      IDLE: if (rx_start) begin
        rx_load = 1'b1;
        rx_next = SHIFT;
      end
      SHIFT: if (bit_en) begin
        rx_shift = 1'b1;
        if (rx_last) rx_next = AFTER_DATA;
      end
      PAR: if (bit_en) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  assign tx_ready  = (tx_state == IDLE);
  assign tx_active = (tx_state != IDLE);

`ifdef SERDES_PARITY_EN
  logic tx_par;

  always_ff @(posedge clk) begin
    if (rst)          tx_par <= 1'b0;
    else if (tx_load) tx_par <= ^tx_data;
  end

  assign tx_tail = tx_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_state == PAR && bit_en) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
        rx_err   <= rx_bit ^ (^rx_word);
      end
    end
  end
`else
  assign tx_tail = IDLE_BIT;
  assign rx_err  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_shift && rx_last) begin
        rx_data  <= rx_word_next;
        rx_valid <= 1'b1;
      end
    end
  end
`endif

  // Line value changes only on the load edge or on an edge that retires a bit
  always_ff @(posedge clk) begin
    if (rst)                            tx_bit <= IDLE_BIT;
    else if (tx_load)                   tx_bit <= msb_first ? tx_data[WIDTH-1] : tx_data[0];
    else if (tx_shift)                  tx_bit <= tx_last ? tx_tail : tx_head_next;
    else if (tx_state == PAR && bit_en) tx_bit <= IDLE_BIT;
  end

endmodule
